// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: channel request bus, output word bus and
// arbitration controls grouped for the rr_mux_n block.
interface rr_mux_n_if #(
   parameter int WIDTH    = 64,
   parameter int CHANNELS = 8
);
   localparam int SELW = $clog2(CHANNELS);

   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_ready;
   logic                      arb_mode;
   logic [SELW-1:0]           sel;
   logic                      out_valid;
   logic [WIDTH-1:0]          out_data;
   logic [SELW-1:0]           out_sel;
   logic                      out_ready;

   modport master (
      output in_valid, in_data, arb_mode, sel, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, arb_mode, sel, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel mux with directed or round-robin grant
// and a single registered output stage (1-cycle latency).
module rr_mux_n #(
   parameter int WIDTH    = 64,
   parameter int CHANNELS = 8,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input logic   clk,
   input logic   reset_n,
   rr_mux_n_if.slave bus
);

   logic [SELW-1:0]     ptr_q, ptr_d;
   logic                valid_q, valid_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic [SELW-1:0]     osel_q, osel_d;

   logic                load;
   logic                rr_hit;
   logic [SELW-1:0]     rr_g;
   logic [SELW-1:0]     idx;
   logic                hit;
   logic [SELW-1:0]     g;
   logic                xfer;

   assign load = !valid_q | bus.out_ready;

   // Descending scan so the channel closest to ptr wins.
   always_comb begin
      rr_hit = 1'b0;
      rr_g   = '0;
      idx    = '0;
      for (int k = CHANNELS-1; k >= 0; k--) begin
         idx = ptr_q + SELW'(k);
         if (bus.in_valid[idx]) begin
            rr_hit = 1'b1;
            rr_g   = idx;
         end
      end
   end

   always_comb begin
      hit = 1'b0;
      g   = '0;
      unique case (1'b1)
         bus.arb_mode: begin
            hit = rr_hit;
            g   = rr_g;
         end
         default: begin
            hit = bus.in_valid[bus.sel];
            g   = bus.sel;
         end
      endcase
   end

   assign xfer = reset_n & load & hit;

   assign bus.in_ready  = xfer ? (CHANNELS'(1) << g) : '0;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = osel_q;

   always_comb begin
      ptr_d   = ptr_q;
      valid_d = valid_q;
      data_d  = data_q;
      osel_d  = osel_q;
      if (xfer) begin
         valid_d = 1'b1;
         data_d  = bus.in_data[int'(g)*WIDTH +: WIDTH];
         osel_d  = g;
         if (bus.arb_mode)
            ptr_d = g + SELW'(1);
      end else if (load) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         osel_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         osel_q  <= osel_d;
      end
   end

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed vector table plus stall and
// asynchronous-reset sequences for rr_mux_n (8 x 64).
module tb_rr_mux_n;

   localparam int W = 64;
   localparam int C = 8;

   typedef struct {
      bit          mode;
      logic [2:0]  sel;
      logic [7:0]  vld;
      bit          ordy;
      logic [7:0]  e_rdy;
      bit          e_ov;
      logic [2:0]  e_os;
      logic [63:0] e_od;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vq[$];

   rr_mux_n_if #(.WIDTH(W), .CHANNELS(C)) bus ();

   rr_mux_n #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input bit m, input logic [2:0] s,
                      input logic [7:0] v, input bit r,
                      input logic [7:0] er, input bit ev,
                      input logic [2:0] es, input logic [63:0] ed);
      vec_t t;
      t = '{m, s, v, r, er, ev, es, ed};
      vq.push_back(t);
   endtask

   task automatic set_pattern();
      for (int i = 0; i < C; i++)
         bus.in_data[i*W +: W] = 64'(i * 'h11);
   endtask

   task automatic chk_out(input string tag, input bit ev,
                          input logic [2:0] es, input logic [63:0] ed);
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
      chk({tag, ".out_sel"}, 64'(bus.out_sel), 64'(es));
      chk({tag, ".out_data"}, bus.out_data, ed);
   endtask

   initial begin
      logic [7:0] one;
      one = 8'd1;
      bus.in_valid  = 8'hFF;
      bus.arb_mode  = 1'b0;
      bus.sel       = 3'd0;
      bus.out_ready = 1'b1;
      set_pattern();

      #12;
      chk("rst.in_ready", 64'(bus.in_ready), 64'h0);
      chk_out("rst", 1'b0, 3'd0, 64'h0);
      @(posedge clk);
      #1 chk_out("rst_edge", 1'b0, 3'd0, 64'h0);

      for (int s = 7; s >= 0; s--)
         add(0, 3'(s), 8'hFF, 1, one << s, 1, 3'(s), 64'(s * 'h11));
      add(0, 3'd3, 8'hF7, 1, 8'h00, 0, 3'd0, 64'h0);
      add(0, 3'd3, 8'hFF, 1, 8'h08, 1, 3'd3, 64'h33);
      for (int k = 0; k < 16; k++)
         add(1, 3'd0, 8'hFF, 1, one << (k % 8), 1, 3'(k % 8),
             64'((k % 8) * 'h11));
      add(1, 3'd0, 8'h10, 1, 8'h10, 1, 3'd4, 64'h44);
      add(1, 3'd0, 8'h06, 1, 8'h02, 1, 3'd1, 64'h11);
      add(1, 3'd0, 8'h06, 1, 8'h04, 1, 3'd2, 64'h22);
      add(1, 3'd0, 8'h06, 1, 8'h02, 1, 3'd1, 64'h11);
      add(0, 3'd6, 8'hFF, 1, 8'h40, 1, 3'd6, 64'h66);
      add(1, 3'd0, 8'hFF, 1, 8'h04, 1, 3'd2, 64'h22);
      add(1, 3'd0, 8'h00, 1, 8'h00, 0, 3'd2, 64'h22);
      add(0, 3'd5, 8'hDF, 1, 8'h00, 0, 3'd2, 64'h22);

      @(negedge clk);
      reset_n = 1'b1;
      foreach (vq[i]) begin
         if (i != 0) @(negedge clk);
         bus.arb_mode  = vq[i].mode;
         bus.sel       = vq[i].sel;
         bus.in_valid  = vq[i].vld;
         bus.out_ready = vq[i].ordy;
         #1 chk($sformatf("v%0d.in_ready", i), 64'(bus.in_ready),
                64'(vq[i].e_rdy));
         @(posedge clk);
         #1 chk_out($sformatf("v%0d", i), vq[i].e_ov, vq[i].e_os,
                    vq[i].e_od);
      end

      // Stall: hold 0xAB while controls and data churn.
      @(negedge clk);
      bus.arb_mode = 1'b0;
      bus.sel = 3'd5;
      bus.in_valid = 8'hFF;
      bus.in_data[5*W +: W] = 64'hAB;
      #1 chk("st_load.in_ready", 64'(bus.in_ready), 64'h20);
      @(posedge clk);
      #1 chk_out("st_load", 1'b1, 3'd5, 64'hAB);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         bus.sel = 3'($urandom_range(0, 7));
         bus.arb_mode = i[0];
         for (int c = 0; c < C; c++)
            bus.in_data[c*W +: W] = {$urandom, $urandom};
         #1 chk($sformatf("st%0d.in_ready", i), 64'(bus.in_ready), 64'h0);
         @(posedge clk);
         #1 chk_out($sformatf("st%0d", i), 1'b1, 3'd5, 64'hAB);
      end
      @(negedge clk);
      set_pattern();
      bus.arb_mode = 1'b0;
      bus.sel = 3'd2;
      bus.out_ready = 1'b1;
      #1 chk("st_rel.in_ready", 64'(bus.in_ready), 64'h04);
      @(posedge clk);
      #1 chk_out("st_rel", 1'b1, 3'd2, 64'h22);

      // Async reset in a stall, with ptr left nonzero.
      @(negedge clk);
      bus.arb_mode = 1'b1;
      bus.in_valid = 8'h04;
      #1 chk("ar_load.in_ready", 64'(bus.in_ready), 64'h04);
      @(posedge clk);
      #1 chk_out("ar_load", 1'b1, 3'd2, 64'h22);
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 8'hFF;
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 chk("ar_low.in_ready", 64'(bus.in_ready), 64'h0);
      chk_out("ar_low", 1'b0, 3'd0, 64'h0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 chk("ar_hold.in_ready", 64'(bus.in_ready), 64'h0);
      chk_out("ar_hold", 1'b0, 3'd0, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("ar_rel.in_ready", 64'(bus.in_ready), 64'h01);
      @(posedge clk);
      #1 chk_out("ar_rel", 1'b1, 3'd0, 64'h0);
      @(negedge clk);
      #1 chk("ar_next.in_ready", 64'(bus.in_ready), 64'h02);
      @(posedge clk);
      #1 chk_out("ar_next", 1'b1, 3'd1, 64'h11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
